// File: rtl/host_cfg_pkg.sv
// Shared definitions for the host configuration register block:
// address map, per-port configuration record and commit FSM states.
package host_cfg_pkg;

    localparam logic [15:0] ADDR_ID     = 16'h0000;
    localparam logic [15:0] ADDR_CTRL   = 16'h0001;
    localparam logic [15:0] ADDR_STATUS = 16'h0002;
    localparam logic [15:0] STAGE_BASE  = 16'h0010;
    localparam logic [15:0] ACTIVE_BASE = 16'h0020;
    localparam logic [15:0] DROP_BASE   = 16'h0030;

    // Each per-port window is 16 registers wide, indexed by the low address bits.
    localparam int PORT_IDX_W = 4;

    typedef struct packed {
        logic [7:0] max_len;
        logic       enable;
    } port_cfg_t;

    localparam port_cfg_t PORT_CFG_RST = '{max_len: 8'hFF, enable: 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLY
    } commit_state_e;

    function automatic logic [15:0] cfg_to_word(input port_cfg_t cfg);
        return {cfg.max_len, 7'b0, cfg.enable};
    endfunction

endpackage

// File: rtl/host_drop_counter.sv
// Saturating 16-bit drop event counter with a synchronous clear that
// takes priority over a simultaneous increment.
module host_drop_counter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/host_cfg_regs.sv
// Host configuration register block for the router: decodes host reads/writes,
// holds staged and active per-port config, and commits staged->active when idle.
module host_cfg_regs
    import host_cfg_pkg::*;
#(
    parameter int          NUM_PORTS = 16,
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 16,
    parameter logic [15:0] ID_VALUE  = 16'h1600
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_n,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_oe,
    input  logic                   router_idle,
    input  logic [NUM_PORTS-1:0]   drop_pulse,
    output logic                   global_en,
    output logic [NUM_PORTS-1:0]   port_en,
    output logic [NUM_PORTS*8-1:0] port_max_len,
    output logic                   cfg_update
);

    logic [ADDR_W-1:0]     addr_page;
    logic [PORT_IDX_W-1:0] port_idx;
    logic                  port_ok;
    logic                  wr_cycle;
    logic                  id_hit;
    logic                  ctrl_hit;
    logic                  status_hit;
    logic                  stage_hit;
    logic                  active_hit;
    logic                  drop_hit;
    logic                  commit_req;
    logic                  unused_data_in;

    logic                  global_en_q;
    port_cfg_t             stage_q  [NUM_PORTS];
    port_cfg_t             active_q [NUM_PORTS];
    commit_state_e         state_q;
    logic                  cfg_update_q;
    logic [15:0]           drop_cnt [NUM_PORTS];
    logic [15:0]           rd_word_d;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  data_oe_q;

    assign wr_cycle  = !wr_n;
    assign addr_page = address >> PORT_IDX_W;
    assign port_idx  = address[PORT_IDX_W-1:0];

    if (NUM_PORTS < (1 << PORT_IDX_W)) begin : g_partial_map
        assign port_ok = 32'(port_idx) < NUM_PORTS;
    end else begin : g_full_map
        assign port_ok = 1'b1;
    end

    assign id_hit     = address == ADDR_W'(ADDR_ID);
    assign ctrl_hit   = address == ADDR_W'(ADDR_CTRL);
    assign status_hit = address == ADDR_W'(ADDR_STATUS);
    assign stage_hit  = port_ok && (addr_page == ADDR_W'(STAGE_BASE >> PORT_IDX_W));
    assign active_hit = port_ok && (addr_page == ADDR_W'(ACTIVE_BASE >> PORT_IDX_W));
    assign drop_hit   = port_ok && (addr_page == ADDR_W'(DROP_BASE >> PORT_IDX_W));
    assign commit_req = wr_cycle && ctrl_hit && data_in[1];

    assign unused_data_in = ^data_in;

    // NOTE: the config arrays are individual flops rather than a RAM, so they carry a reset value.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            global_en_q <= 1'b0;
            for (int n = 0; n < NUM_PORTS; n++) begin
                stage_q[n] <= PORT_CFG_RST;
            end
        end else begin
            if (wr_cycle && ctrl_hit) begin
                global_en_q <= data_in[0];
            end
            if (wr_cycle && stage_hit) begin
                stage_q[port_idx] <= '{max_len: data_in[15:8], enable: data_in[0]};
            end
        end
    end

    // The copy happens on the edge that enters APPLY, so a same-edge staged
    // write is not picked up; cfg_update is high for the whole APPLY cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cfg_update_q <= 1'b0;
            for (int n = 0; n < NUM_PORTS; n++) begin
                active_q[n] <= PORT_CFG_RST;
            end
        end else begin
            cfg_update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (commit_req) begin
                        state_q <= PENDING;
                    end
                end
                PENDING: begin
                    if (router_idle) begin
                        state_q      <= APPLY;
                        cfg_update_q <= 1'b1;
                        active_q     <= stage_q;
                    end
                end
                APPLY: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_word_d = '0;
        if (id_hit) begin
            rd_word_d = ID_VALUE;
        end else if (ctrl_hit) begin
            rd_word_d = {15'b0, global_en_q};
        end else if (status_hit) begin
            rd_word_d = {14'b0, router_idle, state_q != IDLE};
        end else if (stage_hit) begin
            rd_word_d = cfg_to_word(stage_q[port_idx]);
        end else if (active_hit) begin
            rd_word_d = cfg_to_word(active_q[port_idx]);
        end else if (drop_hit) begin
            rd_word_d = drop_cnt[port_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_q <= '0;
            data_oe_q <= 1'b0;
        end else begin
            data_oe_q <= wr_n;
            rd_data_q <= wr_n ? DATA_W'(rd_word_d) : '0;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        host_drop_counter u_drop_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .clear_i (wr_cycle && drop_hit && (port_idx == PORT_IDX_W'(g))),
            .inc_i   (drop_pulse[g]),
            .count_o (drop_cnt[g])
        );

        assign port_en[g]             = active_q[g].enable;
        assign port_max_len[8*g +: 8] = active_q[g].max_len;
    end

    assign global_en  = global_en_q;
    assign cfg_update = cfg_update_q;
    assign data_out   = rd_data_q;
    assign data_oe    = data_oe_q;

endmodule

// File: tb/tb_host_cfg_regs.sv
// Self-checking bench for host_cfg_regs: read data goes through a scoreboard
// queue, direct outputs are sampled 1 time unit after the rising edge.
module tb_host_cfg_regs;

    localparam int NP = 16;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            wr_n;
    logic [15:0]     address;
    logic [15:0]     data_in;
    logic [15:0]     data_out;
    logic            data_oe;
    logic            router_idle;
    logic [NP-1:0]   drop_pulse;
    logic            global_en;
    logic [NP-1:0]   port_en;
    logic [NP*8-1:0] port_max_len;
    logic            cfg_update;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_upd;
    logic [16:0] exp_q[$];
    string       tag_q[$];
    logic [16:0] mon_exp;
    string       mon_tag;

    host_cfg_regs #(
        .NUM_PORTS (NP),
        .ADDR_W    (16),
        .DATA_W    (16),
        .ID_VALUE  (16'h1600)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_n         (wr_n),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .router_idle  (router_idle),
        .drop_pulse   (drop_pulse),
        .global_en    (global_en),
        .port_en      (port_en),
        .port_max_len (port_max_len),
        .cfg_update   (cfg_update)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        wr_n    = 1'b0;
        address = a;
        data_in = d;
        exp_q.push_back({1'b0, 16'h0000});
        tag_q.push_back($sformatf("wr_%0h", a));
        tick();
        wr_n    = 1'b1;
        address = 16'h00FF;
        data_in = '0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
        wr_n    = 1'b1;
        address = a;
        exp_q.push_back({1'b1, exp});
        tag_q.push_back(tag);
        tick();
        address = 16'h00FF;
    endtask

    task automatic count_updates(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (cfg_update) n++;
        end
    endtask

    // Each queued entry matches the edge right after it was pushed; compare on the falling edge.
    always @(posedge clock) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            @(negedge clock);
            check({mon_tag, "_oe"}, data_oe, mon_exp[16]);
            check(mon_tag, data_out, mon_exp[15:0]);
        end
    end

    initial begin
        reset_n     = 1'b0;
        wr_n        = 1'b1;
        address     = '0;
        data_in     = '0;
        router_idle = 1'b0;
        drop_pulse  = '0;
        repeat (3) tick();
        check("rst_oe", data_oe, 0);
        check("rst_upd", cfg_update, 0);
        check("rst_gen", global_en, 0);
        check("rst_port_en", port_en, 0);
        check("rst_max_len", port_max_len, {NP{8'hFF}});
        reset_n = 1'b1;

        do_read(16'h0000, 16'h1600, "id");
        do_read(16'h0010, 16'hFF00, "stage0_rst");
        do_read(16'h0050, 16'h0000, "unmapped");
        do_read(16'h0023, 16'hFF00, "active3_rst");
        do_read(16'h0002, 16'h0000, "status_rst");
        do_read(16'h0031, 16'h0000, "drop1_rst");
        do_write(16'h0000, 16'hBEEF);
        do_read(16'h0000, 16'h1600, "id_ro");

        // Commit with the router already idle.
        do_write(16'h0013, 16'h4001);
        router_idle = 1'b1;
        do_write(16'h0001, 16'h0003);
        check("c1_gen", global_en, 1);
        check("c1_upd_early", cfg_update, 0);
        do_read(16'h0023, 16'hFF00, "active3_pre");
        check("c1_upd", cfg_update, 1);
        check("c1_port_en", port_en, 16'h0008);
        check("c1_len3", port_max_len[31:24], 8'h40);
        do_read(16'h0023, 16'h4001, "active3_post");
        check("c1_upd_end", cfg_update, 0);
        do_read(16'h0001, 16'h0001, "ctrl_rd");

        // Commit held off by a busy router, duplicate commit, same-edge staged write.
        router_idle = 1'b0;
        do_write(16'h0013, 16'h2001);
        do_write(16'h0001, 16'h0003);
        do_read(16'h0002, 16'h0001, "status_pend");
        count_updates(20, n_upd);
        check("pend_no_upd", n_upd, 0);
        do_write(16'h0001, 16'h0003);
        check("c2_upd_early", cfg_update, 0);
        router_idle = 1'b1;
        do_write(16'h0015, 16'h7701);
        check("c2_upd", cfg_update, 1);
        check("c2_port_en", port_en, 16'h0008);
        check("c2_len3", port_max_len[31:24], 8'h20);
        check("c2_len5", port_max_len[47:40], 8'hFF);
        count_updates(6, n_upd);
        check("c2_single", n_upd, 0);
        do_read(16'h0002, 16'h0002, "status_idle");
        do_read(16'h0025, 16'hFF00, "active5");
        do_read(16'h0015, 16'h7701, "stage5");

        // Drop counter count and clear-beats-pulse.
        repeat (5) begin
            drop_pulse = 16'h0080;
            tick();
        end
        drop_pulse = '0;
        do_read(16'h0037, 16'h0005, "drop7");
        drop_pulse = 16'h0080;
        do_write(16'h0037, 16'h0000);
        drop_pulse = '0;
        do_read(16'h0037, 16'h0000, "drop7_clr");
        do_read(16'h0036, 16'h0000, "drop6");

        // Saturation of drop counter 0.
        drop_pulse = 16'h0001;
        repeat (65534) tick();
        drop_pulse = '0;
        do_read(16'h0030, 16'hFFFE, "drop0_near");
        drop_pulse = 16'h0001;
        repeat (6) tick();
        do_read(16'h0030, 16'hFFFF, "drop0_sat");
        drop_pulse = '0;
        do_read(16'h0030, 16'hFFFF, "drop0_hold");

        // Reset while a commit is pending.
        router_idle = 1'b0;
        do_write(16'h0001, 16'h0003);
        check("r_pend_gen", global_en, 1);
        reset_n     = 1'b0;
        router_idle = 1'b1;
        count_updates(2, n_upd);
        check("r_no_upd", n_upd, 0);
        reset_n     = 1'b1;
        router_idle = 1'b0;
        check("r_port_en", port_en, 0);
        check("r_gen", global_en, 0);
        check("r_len", port_max_len, {NP{8'hFF}});
        do_read(16'h0002, 16'h0000, "status_after_rst");
        router_idle = 1'b1;
        count_updates(4, n_upd);
        check("r_idle_no_upd", n_upd, 0);

        repeat (2) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
